// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command engine and the alu it drives.
//   ALU_DATA_WIDTH / ALU_ID_WIDTH : default operand and tag widths
//   alu_op_t                      : 3-bit alu_control encoding (add/sub fixed,
//                                   remaining codes belong to the alu)
//   rsp_t                         : response entry {result, zero, id} at default widths
package alu_pkg;

  localparam int unsigned ALU_DATA_WIDTH = 32;
  localparam int unsigned ALU_ID_WIDTH   = 4;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001
  } alu_op_t;

  typedef struct packed {
    logic [ALU_DATA_WIDTH-1:0] result;
    logic                      zero;
    logic [ALU_ID_WIDTH-1:0]   id;
  } rsp_t;

endpackage

// File: rtl/alu_cmd_engine_if.sv
// Bundles the request channel, the alu initiator bus and the response channel
// of alu_cmd_engine.
//   slave  : the engine's view (accepts requests, drives the alu, returns responses)
//   master : the surrounding view (requester, alu instance, response consumer)
interface alu_cmd_engine_if
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int unsigned ID_WIDTH   = ALU_ID_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;
  logic [ID_WIDTH-1:0]   req_id;

  logic [DATA_WIDTH-1:0] alu_data_1;
  logic [DATA_WIDTH-1:0] alu_data_2;
  logic [2:0]            alu_control;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero_flag;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_zero;
  logic [ID_WIDTH-1:0]   rsp_id;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_id,
    output req_ready,
    output alu_data_1, alu_data_2, alu_control,
    input  alu_result, alu_zero_flag,
    output rsp_valid, rsp_result, rsp_zero, rsp_id,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_id,
    input  req_ready,
    input  alu_data_1, alu_data_2, alu_control,
    output alu_result, alu_zero_flag,
    input  rsp_valid, rsp_result, rsp_zero, rsp_id,
    output rsp_ready
  );

endinterface

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO, DEPTH entries of type T, head-of-queue read.
//   clk, rst : clock, async active-high reset (empties the FIFO)
//   push_i   : write din_i at the tail
//   pop_i    : drop the head entry
//   din_i    : entry to write
//   head_o   : current head entry (meaningful only when !empty_o)
//   empty_o  : no entries stored
//   full_o   : DEPTH entries stored
//   count_o  : number of stored entries
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter type         T     = rsp_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  T                         din_i,
  output T                         head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/alu_cmd_engine.sv
// Issues alu operations for a requester and returns tagged results in order.
//   clk, rst : clock (rising edge), async active-high reset
//   bus      : alu_cmd_engine_if.slave -- request channel (req_*), alu
//              initiator bus (alu_data_1/2, alu_control, alu_result,
//              alu_zero_flag) and response channel (rsp_*)
//   op_count : responses delivered since reset, wraps at 2^CNT_WIDTH
module alu_cmd_engine
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int unsigned ID_WIDTH   = ALU_ID_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_cmd_engine_if.slave      bus,
  output logic [CNT_WIDTH-1:0] op_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic [ID_WIDTH-1:0]   id;
  } entry_t;

  logic                  issue_valid_q, issue_valid_d;
  logic [ID_WIDTH-1:0]   issue_id_q,    issue_id_d;
  logic [DATA_WIDTH-1:0] data_1_q,      data_1_d;
  logic [DATA_WIDTH-1:0] data_2_q,      data_2_d;
  logic [2:0]            control_q,     control_d;
  logic [CNT_WIDTH-1:0]  op_count_q,    op_count_d;
  entry_t                last_q,        last_d;

  logic          accept;
  logic          pop;
  entry_t        push_entry;
  entry_t        head;
  entry_t        rsp_sel;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;

  // Credit check counts the op still in the issue stage, since it will push
  // next edge; a pop only frees a slot once fifo_count has updated.
  assign bus.req_ready = ~rst & ((fifo_count + CW'(issue_valid_q)) < CW'(DEPTH));
  assign accept        = bus.req_valid & bus.req_ready;
  assign pop           = bus.rsp_valid & bus.rsp_ready;

  always_comb begin
    issue_valid_d = accept;
    issue_id_d    = issue_id_q;
    data_1_d      = data_1_q;
    data_2_d      = data_2_q;
    control_d     = control_q;
    if (accept) begin
      issue_id_d = bus.req_id;
      data_1_d   = bus.req_a;
      data_2_d   = bus.req_b;
      control_d  = bus.req_op;
    end
    op_count_d = pop ? op_count_q + CNT_WIDTH'(1) : op_count_q;
    last_d     = pop ? head : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid_q <= 1'b0;
      issue_id_q    <= '0;
      data_1_q      <= '0;
      data_2_q      <= '0;
      control_q     <= '0;
      op_count_q    <= '0;
      last_q        <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_id_q    <= issue_id_d;
      data_1_q      <= data_1_d;
      data_2_q      <= data_2_d;
      control_q     <= control_d;
      op_count_q    <= op_count_d;
      last_q        <= last_d;
    end
  end

  assign push_entry = '{result: bus.alu_result, zero: bus.alu_zero_flag, id: issue_id_q};

  alu_rsp_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (issue_valid_q),
    .pop_i   (pop),
    .din_i   (push_entry),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // The FIFO head slot is stale once empty, so the last popped entry is
  // replayed to keep rsp_* stable while idle.
  assign rsp_sel        = fifo_empty ? last_q : head;
  assign bus.rsp_valid  = ~fifo_empty;
  assign bus.rsp_result = rsp_sel.result;
  assign bus.rsp_zero   = rsp_sel.zero;
  assign bus.rsp_id     = rsp_sel.id;

  assign bus.alu_data_1  = data_1_q;
  assign bus.alu_data_2  = data_2_q;
  assign bus.alu_control = control_q;
  assign op_count        = op_count_q;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(issue_valid_q && fifo_full));

endmodule

// File: tb/tb_alu_cmd_engine.sv
// Directed self-checking bench for alu_cmd_engine with a behavioural alu model.
module tb_alu_cmd_engine;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_engine_if #(.DATA_WIDTH(32), .ID_WIDTH(4)) bus ();
  alu_cmd_engine_if #(.DATA_WIDTH(32), .ID_WIDTH(4)) bus_w ();
  logic [15:0] op_count;
  logic [3:0]  op_count_w;

  alu_cmd_engine #(
    .DATA_WIDTH (32),
    .ID_WIDTH   (4),
    .DEPTH      (4),
    .CNT_WIDTH  (16)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_count (op_count)
  );

  alu_cmd_engine #(
    .DATA_WIDTH (32),
    .ID_WIDTH   (4),
    .DEPTH      (4),
    .CNT_WIDTH  (4)
  ) u_dut_w (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_w),
    .op_count (op_count_w)
  );

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign bus.alu_result      = alu_model(bus.alu_control, bus.alu_data_1, bus.alu_data_2);
  assign bus.alu_zero_flag   = (bus.alu_result == '0);
  assign bus_w.alu_result    = alu_model(bus_w.alu_control, bus_w.alu_data_1, bus_w.alu_data_2);
  assign bus_w.alu_zero_flag = (bus_w.alu_result == '0);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic single_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] id,
                           input logic [31:0] exp_res, input logic exp_zero,
                           input logic [15:0] exp_cnt);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_id    = id;
    check_eq({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    step();
    bus.req_valid = 1'b0;
    check_eq({tag, "_alu_d1"}, 64'(bus.alu_data_1), 64'(a));
    check_eq({tag, "_alu_d2"}, 64'(bus.alu_data_2), 64'(b));
    check_eq({tag, "_alu_ctl"}, 64'(bus.alu_control), 64'(op));
    check_eq({tag, "_no_early_rsp"}, 64'(bus.rsp_valid), 64'd0);
    step();
    check_eq({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    check_eq({tag, "_rsp_result"}, 64'(bus.rsp_result), 64'(exp_res));
    check_eq({tag, "_rsp_zero"}, 64'(bus.rsp_zero), 64'(exp_zero));
    check_eq({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'(id));
    step();
    check_eq({tag, "_rsp_drained"}, 64'(bus.rsp_valid), 64'd0);
    check_eq({tag, "_rsp_hold"}, 64'(bus.rsp_result), 64'(exp_res));
    check_eq({tag, "_op_count"}, 64'(op_count), 64'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    logic rdy;

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_id = '0;
    bus.rsp_ready = 1'b0;
    bus_w.req_valid = 1'b0; bus_w.req_op = '0; bus_w.req_a = '0; bus_w.req_b = '0;
    bus_w.req_id = '0; bus_w.rsp_ready = 1'b0;

    // Reset state
    #2;
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_alu_d1", 64'(bus.alu_data_1), 64'd0);
    check_eq("rst_alu_ctl", 64'(bus.alu_control), 64'd0);
    check_eq("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check_eq("rst_op_count", 64'(op_count), 64'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", 64'(bus.req_ready), 64'd1);

    // Single op and zero flag
    single_op("add", 3'b000, 32'd1, 32'd2, 4'd3, 32'd3, 1'b0, 16'd1);
    single_op("sub0", 3'b001, 32'd3, 32'd3, 4'd5, 32'd0, 1'b1, 16'd2);
    step();
    check_eq("idle_alu_hold_d1", 64'(bus.alu_data_1), 64'd3);
    check_eq("idle_alu_hold_ctl", 64'(bus.alu_control), 64'd1);

    // Backpressure: rsp_ready low, request held valid
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'b000;
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      bus.req_id = 4'(n_acc);
      bus.req_a  = 32'h100 + 32'(n_acc);
      bus.req_b  = 32'(n_acc);
      rdy = bus.req_ready;
      step();
      if (rdy) n_acc++;
    end
    bus.req_valid = 1'b0;
    check_eq("bp_accepted", 64'(n_acc), 64'd4);
    check_eq("bp_ready_low", 64'(bus.req_ready), 64'd0);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("bp_valid_%0d", k), 64'(bus.rsp_valid), 64'd1);
      check_eq($sformatf("bp_id_%0d", k), 64'(bus.rsp_id), 64'(k));
      check_eq($sformatf("bp_res_%0d", k), 64'(bus.rsp_result), 64'(32'h100 + 32'(2 * k)));
      if (k == 0) check_eq("bp_ready_before_pop", 64'(bus.req_ready), 64'd0);
      step();
      if (k == 0) check_eq("bp_ready_after_pop", 64'(bus.req_ready), 64'd1);
    end
    check_eq("bp_empty", 64'(bus.rsp_valid), 64'd0);
    check_eq("bp_op_count", 64'(op_count), 64'd6);

    // Streaming after a fresh reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    bus.rsp_ready = 1'b1;
    for (int j = 0; j <= 16; j++) begin
      if (j < 16) begin
        bus.req_valid = 1'b1;
        bus.req_id    = 4'(j);
        bus.req_a     = 32'(j);
        bus.req_b     = 32'(3 * j);
        bus.req_op    = 3'b000;
      end else begin
        bus.req_valid = 1'b0;
      end
      check_eq($sformatf("st_ready_%0d", j), 64'(bus.req_ready), 64'd1);
      step();
      if (j >= 1) begin
        check_eq($sformatf("st_valid_%0d", j - 1), 64'(bus.rsp_valid), 64'd1);
        check_eq($sformatf("st_id_%0d", j - 1), 64'(bus.rsp_id), 64'((j - 1) % 16));
        check_eq($sformatf("st_res_%0d", j - 1), 64'(bus.rsp_result), 64'(4 * (j - 1)));
      end
    end
    step();
    check_eq("st_op_count", 64'(op_count), 64'd16);
    check_eq("st_empty", 64'(bus.rsp_valid), 64'd0);

    // Reset with 3 queued and 1 in flight
    bus.rsp_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bus.req_valid = 1'b1;
      bus.req_id    = 4'(8 + j);
      bus.req_a     = 32'(j);
      bus.req_b     = 32'd1;
      step();
    end
    bus.req_valid = 1'b0;
    check_eq("mid_pre_valid", 64'(bus.rsp_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("mid_op_count", 64'(op_count), 64'd0);
    check_eq("mid_req_ready", 64'(bus.req_ready), 64'd0);
    step();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      check_eq($sformatf("mid_no_stale_%0d", j), 64'(bus.rsp_valid), 64'd0);
    end
    check_eq("mid_op_count_after", 64'(op_count), 64'd0);
    single_op("and", 3'b010, 32'hF0, 32'h3C, 4'd9, 32'h30, 1'b0, 16'd1);

    // Counter wrap on the 4-bit instance
    bus_w.rsp_ready = 1'b1;
    for (int j = 0; j < 17; j++) begin
      bus_w.req_valid = 1'b1;
      bus_w.req_id    = 4'(j);
      bus_w.req_a     = 32'(j);
      bus_w.req_b     = 32'd7;
      step();
    end
    bus_w.req_valid = 1'b0;
    repeat (3) step();
    check_eq("wrap_op_count", 64'(op_count_w), 64'd1);
    check_eq("wrap_empty", 64'(bus_w.rsp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_engine.md
Name: alu_cmd_engine

Overview:
Issues ALU operations on behalf of a requester. It accepts commands over a valid/ready request channel and drives the combinational alu block's data_1/data_2/alu_control inputs from registers. It captures result/zero_flag into a response FIFO and returns them over a valid/ready response channel, tagged with the request ID. It is the initiator side of the alu interface and sits between the datapath controller and the alu instance.

Parameters:
DATA_WIDTH, 32, operand/result width (must match the alu)
ID_WIDTH, 4, request tag width
DEPTH, 4, response FIFO entries; power of two, >= 2
CNT_WIDTH, 16, completed-operation counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  engine can accept a request this cycle
req_op  input  3  alu_control code to issue
req_a  input  DATA_WIDTH  operand for data_1
req_b  input  DATA_WIDTH  operand for data_2
req_id  input  ID_WIDTH  tag returned with the response
alu_data_1  output  DATA_WIDTH  to alu data_1
alu_data_2  output  DATA_WIDTH  to alu data_2
alu_control  output  3  to alu alu_control
alu_result  input  DATA_WIDTH  from alu result
alu_zero_flag  input  1  from alu zero_flag
rsp_valid  output  1  FIFO head valid
rsp_ready  input  1  consumer accepts the head
rsp_result  output  DATA_WIDTH  head result
rsp_zero  output  1  head zero flag
rsp_id  output  ID_WIDTH  head tag
op_count  output  CNT_WIDTH  responses delivered since reset

Behaviour:
- Reset (async assert, sync release): issue stage invalid; alu_data_1/alu_data_2/alu_control = 0; FIFO empty; rsp_valid = 0; rsp_result/rsp_zero/rsp_id = 0; op_count = 0; req_ready = 0 while rst is high.
- Acceptance: a request transfers on a clk edge where req_valid && req_ready.
- req_ready = (fifo_count + issue_valid) < DEPTH, computed from registered state only. There is no same-cycle lookahead on pop: a pop frees a slot the following cycle.
- Issue stage: on acceptance, register req_a/req_b/req_op onto the alu_* outputs, register req_id, and set issue_valid = 1. Otherwise issue_valid = 0 and alu_* outputs hold their last values (no toggling when idle).
- Capture: on every edge where issue_valid = 1, push {alu_result, alu_zero_flag, issue_id} into the FIFO. The credit rule guarantees no overflow; pushing when full is a design error and must be flagged by an assertion.
- Latency: request accepted at edge N; alu inputs valid in cycle N..N+1; pushed at edge N+1; rsp_valid high from cycle after N+1, i.e. 2 edges minimum.
- Throughput: 1 op/cycle sustained while rsp_ready stays high.
- Response: rsp_* are driven from the FIFO head, in order. A pop occurs on an edge with rsp_valid && rsp_ready. When empty, rsp_valid = 0 and rsp_* hold their last values.
- Simultaneous push and pop: both occur and fifo_count is unchanged. Pointers wrap modulo DEPTH.
- op_count increments on each pop and wraps modulo 2^CNT_WIDTH.
- Reset mid-operation: the in-flight op and all FIFO contents are discarded; no response is emitted for them.
- The engine does not interpret op codes; any 3-bit value passes through.

Decomposition:
- Package alu_pkg: alu_op_t (3-bit) with ALU_ADD=3'b000, ALU_SUB=3'b001 and the remaining codes as owned by the alu; DATA_WIDTH default constant; response struct {result, zero, id}.
- Sub-module alu_rsp_fifo: synchronous FIFO with DEPTH entries of the response struct, exposing count, push, pop, head, empty and full.

Test Plan:
- Single op, bench-modelled alu: a=1, b=2, op=000, id=3, rsp_ready=1 -> rsp_valid 2 edges after acceptance; rsp_result=3, rsp_zero=0, rsp_id=3; op_count=1.
- Zero flag: a=3, b=3, op=001 -> rsp_result=0, rsp_zero=1.
- Backpressure, DEPTH=4, rsp_ready=0, req_valid held high -> exactly 4 accepted; req_ready=0 from then on. Raising rsp_ready drains ids 0,1,2,3 in order, and req_ready reasserts the cycle after the first pop.
- Streaming: 16 back-to-back requests with rsp_ready=1 -> one response per cycle after the 2-cycle fill; ids in order; op_count=16.
- Reset mid-stream: assert rst with 3 entries queued and 1 in flight -> rsp_valid=0 immediately, op_count=0, no stale responses after release.
- Wrap: set CNT_WIDTH=4 and complete 17 ops -> op_count=1.
